// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage core: tracks E/M/W GRF writers, raises stall/flush_e and picks forwarding sources.
// Optional MDU busy tracking is enabled by defining HAZARD_MDU_EN.
module hazard_sched #(
  parameter logic [1:0]  TUSE_NONE = 2'd3,
  parameter int unsigned MULT_CYC  = 5,
  parameter int unsigned DIV_CYC   = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic       d_we,
  input  logic [1:0] d_tnew_e,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       flush_e,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       mdu_busy
);

  typedef struct packed {
    logic       we;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
`ifdef HAZARD_MDU_EN
    logic       md_start;
    logic       md_div;
`endif
  } e_rec_t;

  typedef struct packed {
    logic       we;
    logic [4:0] a3;
    logic [1:0] tnew;
  } m_rec_t;

  typedef struct packed {
    logic       we;
    logic [4:0] a3;
  } w_rec_t;

  e_rec_t e_q, e_d;
  m_rec_t m_q, m_d;
  w_rec_t w_q, w_d;

  logic rs_stall, rt_stall, md_stall;

  function automatic logic live(input logic we, input logic [4:0] a3, input logic [4:0] r);
    return we && (a3 == r) && (r != 5'd0);
  endfunction

  // Nearest live writer decides; an older ready copy behind a younger pending one is stale.
  function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                    input e_rec_t e, input m_rec_t m);
    if (tuse == TUSE_NONE)     return 1'b0;
    if (live(e.we, e.a3, r))   return e.tnew > tuse;
    if (live(m.we, m.a3, r))   return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] d_fwd(input logic [4:0] r, input e_rec_t e, input m_rec_t m);
    if (live(e.we, e.a3, r)) return (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    if (live(m.we, m.a3, r)) return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] e_fwd(input logic [4:0] r, input m_rec_t m, input w_rec_t w);
    if (live(m.we, m.a3, r)) return (m.tnew == 2'd0) ? 2'd1 : 2'd0;
    if (live(w.we, w.a3, r)) return 2'd2;
    return 2'd0;
  endfunction

`ifdef HAZARD_MDU_EN
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (e_q.md_start)
      cnt_d = e_q.md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign md_stall = d_md_use & (e_q.md_start | (cnt_q != '0));
  assign mdu_busy = (cnt_q != '0);
`else
  logic unused_md;
  assign unused_md = ^{d_md_start, d_md_div, d_md_use, MULT_CYC, DIV_CYC};
  assign md_stall  = 1'b0;
  assign mdu_busy  = 1'b0;
`endif

  always_comb begin
    rs_stall = op_stall(d_rs, d_tuse_rs, e_q, m_q);
    rt_stall = op_stall(d_rt, d_tuse_rt, e_q, m_q);
    stall    = rs_stall | rt_stall | md_stall;
    flush_e  = stall;
    fwd_d_rs = d_fwd(d_rs, e_q, m_q);
    fwd_d_rt = d_fwd(d_rt, e_q, m_q);
    fwd_e_rs = e_fwd(e_q.rs, m_q, w_q);
    fwd_e_rt = e_fwd(e_q.rt, m_q, w_q);
  end

  // The record shift never stops; a stall only swaps the incoming E record for a bubble.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.we   = d_we;
      e_d.a3   = d_a3;
      e_d.tnew = d_tnew_e;
      e_d.rs   = d_rs;
      e_d.rt   = d_rt;
`ifdef HAZARD_MDU_EN
      e_d.md_start = d_md_start;
      e_d.md_div   = d_md_div;
`endif
    end
    m_d      = '0;
    m_d.we   = e_q.we;
    m_d.a3   = e_q.a3;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    w_d      = '0;
    w_d.we   = m_q.we;
    w_d.a3   = m_q.a3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: vector table for the pipeline stream plus MDU and async-reset sequences.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew_e;
  logic       d_we, d_md_start, d_md_div, d_md_use;
  logic       stall, flush_e, mdu_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int checks   = 0;
  int failures = 0;

  hazard_sched #(.TUSE_NONE(2'd3), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_we(d_we), .d_tnew_e(d_tnew_e),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .flush_e(flush_e),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .mdu_busy(mdu_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, a3;
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic       we;
    logic       stall;
    logic [1:0] fdrs, fdrt, fers, fert;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                              input int a3, input int we, input int tnew,
                              input int st, input int fdrs, input int fdrt,
                              input int fers, input int fert);
    vec_t v;
    v.rs = 5'(rs); v.tuse_rs = 2'(tuse_rs); v.rt = 5'(rt); v.tuse_rt = 2'(tuse_rt);
    v.a3 = 5'(a3); v.we = 1'(we); v.tnew = 2'(tnew);
    v.stall = 1'(st); v.fdrs = 2'(fdrs); v.fdrt = 2'(fdrt); v.fers = 2'(fers); v.fert = 2'(fert);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                       input int a3, input int we, input int tnew,
                       input int mds, input int mdd, input int mdu);
    d_rs = 5'(rs); d_tuse_rs = 2'(tuse_rs); d_rt = 5'(rt); d_tuse_rt = 2'(tuse_rt);
    d_a3 = 5'(a3); d_we = 1'(we); d_tnew_e = 2'(tnew);
    d_md_start = 1'(mds); d_md_div = 1'(mdd); d_md_use = 1'(mdu);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"},   int'(stall),    0);
    chk({tag, ".flush"},   int'(flush_e),  0);
    chk({tag, ".fwd_d_rs"}, int'(fwd_d_rs), 0);
    chk({tag, ".fwd_d_rt"}, int'(fwd_d_rt), 0);
    chk({tag, ".fwd_e_rs"}, int'(fwd_e_rs), 0);
    chk({tag, ".fwd_e_rt"}, int'(fwd_e_rt), 0);
    chk({tag, ".busy"},    int'(mdu_busy), 0);
  endtask

  // mult/div followed by a held mflo; expected stall/busy windows given in cycles.
  task automatic md_seq(input int div, input int stall_n, input int busy_n);
    @(negedge clk);
    drive(0, 3, 0, 3, 0, 0, 0, 1, div, 1);
    #1;
    chk($sformatf("md%0d.issue.stall", div), int'(stall), 0);
    chk($sformatf("md%0d.issue.busy", div), int'(mdu_busy), 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(0, 3, 0, 3, 7, 1, 1, 0, 0, 1);
      #1;
      chk($sformatf("md%0d.c%0d.stall", div, i), int'(stall), (i < stall_n) ? 1 : 0);
      chk($sformatf("md%0d.c%0d.busy", div, i), int'(mdu_busy), (i >= 1 && i <= busy_n) ? 1 : 0);
    end
  endtask

  initial begin
    vecs[0]  = mk( 2,1,  0,3,  1,1,2,  0,0,0,0,0);  // lw $1
    vecs[1]  = mk( 1,1,  3,1,  2,1,1,  1,0,0,0,0);  // addu $2,$1,$3 stalls
    vecs[2]  = mk( 1,1,  3,1,  2,1,1,  0,0,0,0,0);
    vecs[3]  = mk( 0,3,  0,3,  0,0,0,  0,0,0,2,0);  // addu in E takes W
    vecs[4]  = mk( 4,1,  5,1,  1,1,1,  0,0,0,0,0);  // addu $1
    vecs[5]  = mk( 1,0,  0,0,  0,0,0,  1,0,0,0,0);  // beq $1,$0
    vecs[6]  = mk( 1,0,  0,0,  0,0,0,  0,2,0,0,0);
    vecs[7]  = mk( 0,3,  0,3, 31,1,0,  0,0,0,2,0);  // jal
    vecs[8]  = mk(31,0, 31,0,  0,0,0,  0,1,1,0,0);  // jr-like read of $31 twice
    vecs[9]  = mk( 0,1,  0,3,  0,1,1,  0,0,0,1,1);  // ori $0
    vecs[10] = mk( 0,0,  0,0,  0,0,0,  0,0,0,0,0);  // beq $0,$0
    vecs[11] = mk( 6,1,  7,1,  5,1,1,  0,0,0,0,0);  // addu $5
    vecs[12] = mk( 8,1,  0,3,  5,1,2,  0,0,0,0,0);  // lw $5
    vecs[13] = mk( 5,1,  5,2,  9,1,1,  1,0,0,0,0);  // E beats ready M
    vecs[14] = mk( 5,1,  5,2,  9,1,1,  0,0,0,0,0);  // W never feeds D
    vecs[15] = mk( 0,3,  0,3,  0,0,0,  0,0,0,2,2);
    vecs[16] = mk(10,1,  0,3,  6,1,2,  0,0,0,0,0);  // lw $6
    vecs[17] = mk(11,1, 12,1,  6,1,1,  0,0,0,0,0);  // addu $6
    vecs[18] = mk( 6,1,  6,1, 13,1,1,  0,0,0,0,0);
    vecs[19] = mk( 0,3,  0,3,  0,0,0,  0,0,0,1,1);  // M beats W in E

    reset_n = 1'b0;
    drive(1, 0, 1, 0, 1, 1, 2, 1, 0, 1);
    #1;
    chk_all_zero("reset0");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset1");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].tuse_rs, vecs[i].rt, vecs[i].tuse_rt,
            vecs[i].a3, vecs[i].we, vecs[i].tnew, 0, 0, 0);
      #1;
      chk($sformatf("v%0d.stall", i),    int'(stall),    int'(vecs[i].stall));
      chk($sformatf("v%0d.flush", i),    int'(flush_e),  int'(vecs[i].stall));
      chk($sformatf("v%0d.fwd_d_rs", i), int'(fwd_d_rs), int'(vecs[i].fdrs));
      chk($sformatf("v%0d.fwd_d_rt", i), int'(fwd_d_rt), int'(vecs[i].fdrt));
      chk($sformatf("v%0d.fwd_e_rs", i), int'(fwd_e_rs), int'(vecs[i].fers));
      chk($sformatf("v%0d.fwd_e_rt", i), int'(fwd_e_rt), int'(vecs[i].fert));
    end

`ifdef HAZARD_MDU_EN
    md_seq(0, 6, 5);
    md_seq(1, 11, 10);
`else
    md_seq(0, 0, 0);
    md_seq(1, 0, 0);
`endif

    @(negedge clk);
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 3, 0, 3, 1, 1, 1, 0, 0, 0);            // addu $1
    @(negedge clk);
    drive(1, 1, 0, 3, 1, 1, 2, 0, 0, 0);            // lw $1,($1)
    #1;
    chk("rst.pre.lw_stall", int'(stall), 0);
    @(negedge clk);
    drive(1, 1, 0, 3, 3, 1, 1, 0, 0, 0);            // addu $3,$1 behind lw
    #1;
    chk("rst.pre.stall",    int'(stall),    1);
    chk("rst.pre.flush",    int'(flush_e),  1);
    chk("rst.pre.fwd_e_rs", int'(fwd_e_rs), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    @(posedge clk);
    #1;
    chk_all_zero("rst.held");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst.post%0d.stall", i),    int'(stall),    0);
      chk($sformatf("rst.post%0d.fwd_e_rs", i), int'(fwd_e_rs), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
